// File: rtl/csa_serial_wide_adder.sv
// rtl/csa_serial_wide_adder.sv - chunk-serial WIDTH-bit adder built around one 8-bit carry-skip adder
//
// jcarryskipadder: combinational 8-bit carry-skip adder (two 4-bit ripple
//   blocks, each with a skip path taken when the whole block propagates).
//   a, b   : 8-bit operands
//   cin    : carry in
//   s      : 8-bit sum
//   cout   : carry out
//
// csa_serial_wide_adder: accepts one WIDTH-bit operand pair over in_valid/in_ready,
//   adds it one 8-bit chunk per cycle (LSB chunk first) through a single
//   jcarryskipadder, and presents the sum over out_valid/out_ready.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand pair valid
//   in_ready   : stage can accept operands (IDLE only, low during reset)
//   A, B       : WIDTH-bit operands
//   carryin    : carry into bit 0
//   out_valid  : result valid (DONE only)
//   out_ready  : downstream accepts result
//   Y          : sum, (A+B+carryin) mod 2^WIDTH
//   carryout   : bit WIDTH of A+B+carryin
//   overflow   : two's-complement overflow of the sum

module jcarryskipadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [4:0] w_c_lo;
  logic [4:0] w_c_hi;
  logic [7:0] w_p;
  logic       w_blk0_cout;

  always_comb begin
    s           = '0;
    w_c_lo      = '0;
    w_c_hi      = '0;
    w_p         = a ^ b;
    w_blk0_cout = 1'b0;
    cout        = 1'b0;

    w_c_lo[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]        = w_p[i] ^ w_c_lo[i];
      w_c_lo[i+1] = (a[i] & b[i]) | (w_p[i] & w_c_lo[i]);
    end
    // Block fully propagating: carry-in bypasses the ripple chain.
    w_blk0_cout = (&w_p[3:0]) ? cin : w_c_lo[4];

    w_c_hi[0] = w_blk0_cout;
    for (int i = 0; i < 4; i++) begin
      s[i+4]      = w_p[i+4] ^ w_c_hi[i];
      w_c_hi[i+1] = (a[i+4] & b[i+4]) | (w_p[i+4] & w_c_hi[i]);
    end
    cout = (&w_p[7:4]) ? w_blk0_cout : w_c_hi[4];
  end

endmodule

module csa_serial_wide_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carryout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / 8;
  localparam int IDXW   = $clog2(NCHUNK) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_cbit;

  logic [7:0]       w_a_chunk;
  logic [7:0]       w_b_chunk;
  logic [7:0]       w_sum;
  logic             w_cout;

  // Current chunk is selected by shifting the held operands down by 8*idx.
  assign w_a_chunk = 8'(r_op_a >> {r_idx, 3'b000});
  assign w_b_chunk = 8'(r_op_b >> {r_idx, 3'b000});

  jcarryskipadder u_adder (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_cbit),
    .s    (w_sum),
    .cout (w_cout)
  );

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      Y        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= A;
            r_op_b  <= B;
            r_cbit  <= carryin;
            r_idx   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
              Y[8*k +: 8] <= w_sum;
            end
          end
          r_cbit <= w_cout;
          if (r_idx == IDXW'(NCHUNK - 1)) begin
            carryout <= w_cout;
            // Carry into the MSB is a^b^s there; overflow is it XOR carry-out.
            overflow <= r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1] ^ w_sum[7] ^ w_cout;
            r_idx    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_wide_adder.sv
// tb/tb_csa_serial_wide_adder.sv - self-checking bench for csa_serial_wide_adder

module tb_csa_serial_wide_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        carryin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        carryout;
  logic        overflow;

  int total;
  int bad;

  logic [31:0] m_y;
  logic        m_co;
  logic        m_ov;
  logic        m_valid;

  csa_serial_wide_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic model: 33-bit sum, overflow from operand/result signs.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] y, output logic co, output logic ov);
    logic [32:0] s;
    s  = {1'b0, a} + {1'b0, b} + {32'd0, c};
    y  = s[31:0];
    co = s[32];
    ov = (a[31] == b[31]) && (s[31] != a[31]);
  endtask

  // Continuous comparison against the model whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!m_valid) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected_valid: got out_valid=1 expected 0");
      end else begin
        check("mon_y", {32'd0, Y}, {32'd0, m_y});
        check("mon_co", {63'd0, carryout}, {63'd0, m_co});
        check("mon_ov", {63'd0, overflow}, {63'd0, m_ov});
        check("mon_in_ready", {63'd0, in_ready}, 64'd0);
      end
    end
  end

  // Issue one operation; returns the edge count from accept to out_valid.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    A = a;
    B = b;
    carryin = c;
    in_valid = 1'b1;
    model(a, b, c, m_y, m_co, m_ov);
    m_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_valid = 1'b0;
    check("out_valid_drop", {63'd0, out_valid}, 64'd0);
    check("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] ey, input logic eco, input logic eov);
    int lat;
    logic [31:0] py;
    logic pco, pov;
    // Pin the model itself to the hand-computed values.
    model(a, b, c, py, pco, pov);
    check({name, "_model_y"}, {32'd0, py}, {32'd0, ey});
    check({name, "_model_co"}, {63'd0, pco}, {63'd0, eco});
    check({name, "_model_ov"}, {63'd0, pov}, {63'd0, eov});
    launch(a, b, c, lat);
    check({name, "_latency"}, 64'(lat), 64'd4);
    check({name, "_y"}, {32'd0, Y}, {32'd0, ey});
    check({name, "_co"}, {63'd0, carryout}, {63'd0, eco});
    check({name, "_ov"}, {63'd0, overflow}, {63'd0, eov});
    finish_op();
  endtask

  initial begin
    int lat;
    logic [31:0] held_y;
    total = 0;
    bad = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    carryin = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y", {32'd0, Y}, 64'd0);
    check("rst_co", {63'd0, carryout}, 64'd0);
    check("rst_ov", {63'd0, overflow}, 64'd0);
    check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);

    run_op("t2", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    run_op("t3", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t4a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("t4b", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("carry_mid", 32'h00FF_FF00, 32'h0000_0100, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Result held with out_ready low while new operands are offered.
    launch(32'hA5A5_0F0F, 32'h1234_F0F1, 1'b0, lat);
    check("t5_latency", 64'(lat), 64'd4);
    check("t5_y", {32'd0, Y}, 64'h0000_0000_B7DA_0000);
    held_y = Y;
    for (int i = 0; i < 10; i++) begin
      A = 32'hDEAD_0000 + 32'(i);
      B = 32'h0000_BEEF;
      in_valid = i[0];
      @(negedge clk);
      check("t5_in_ready", {63'd0, in_ready}, 64'd0);
      check("t5_hold_y", {32'd0, Y}, {32'd0, held_y});
      check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    finish_op();

    // Reset in the second BUSY cycle aborts the operation.
    launch_abort();
    run_op("t6", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic launch_abort;
    A = 32'h1234_5678;
    B = 32'h1111_1111;
    carryin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_valid", {63'd0, out_valid}, 64'd0);
    end
    check("t6_idle", {63'd0, in_ready}, 64'd1);
  endtask

endmodule
